mem_arbiter_1rw: RTL and testbench
==================================

# mem_arbiter_1rw

Two-requester round-robin arbiter that shares one single-port (1RW) synchronous-read memory, such as the 32x64 `Memory1RW`, between two independent clients. Each client issues one read or write per cycle through a valid/ready handshake. The arbiter drives the memory's shared address, write-enable and write-data port. One cycle after each grant it returns a completion and any read data to the client that won the grant. It sits directly in front of the memory instance, replacing a direct client connection.

## Interface
Parameters:
- `ADDR_W`, default 5: memory address width.
- `DATA_W`, default 64: memory data width.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clock`).
- `r0_valid`  in  1  client 0 request valid.
- `r0_ready`  out  1  client 0 request accepted this cycle (grant).
- `r0_we`  in  1  client 0 request type: 1 = write, 0 = read.
- `r0_addr`  in  ADDR_W  client 0 address.
- `r0_wdata`  in  DATA_W  client 0 write data.
- `r0_resp_valid`  out  1  client 0 completion pulse.
- `r0_rdata`  out  DATA_W  client 0 read data, qualified by `r0_resp_valid`.
- `r1_valid`, `r1_ready`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_resp_valid`, `r1_rdata`: client 1, same directions, widths and meanings as client 0.
- `mem_addr`  out  ADDR_W  address to the memory RW port.
- `mem_we`  out  1  write enable (wmode) to the memory RW port.
- `mem_wdata`  out  DATA_W  write data to the memory RW port.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after the address is presented.

## Operation
Grant logic is combinational from the valid inputs and the state:
- Only one client valid: that client is granted.
- Both clients valid: the client not recorded in `last` is granted.
- Neither valid: no grant.

`rN_ready` equals the grant for client N. A request transfers when `rN_valid && rN_ready` in the same cycle.

Memory drive:
- Granted cycle: `mem_addr`, `mem_we` and `mem_wdata` carry the granted client's fields.
- No grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

State:
- `last` (1 bit): updated to the granted client id on each grant and held otherwise.
- Response register: `rsp_v`, `rsp_id`, `rsp_we`, loaded every cycle from the grant (`rsp_v`=0 when there is no grant).

Response (cycle after grant):
- `r[rsp_id]_resp_valid`=1 for exactly one cycle, for both reads and writes.
- Read: `r[rsp_id]_rdata` = `mem_rdata`.
- Write: `r[rsp_id]_rdata` = 0.
- The non-addressed client sees `resp_valid`=0 and `rdata`=0.

General rules:
- Responses cannot be backpressured. Clients must accept them.
- Requests are never queued. An unaccepted request must be held stable by the client until it is granted.
- Single-port memory means at most one access per cycle. The aggregate throughput limit is 1 access/cycle.

## Timing
- Reset (`reset`=0 at an edge): `last`=1, so client 0 wins the first contention. `rsp_v`=0.
- While `reset`=0: `r0_ready`=`r1_ready`=0, all `resp_valid`=0, all `rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted mid-operation: any pending response is dropped and no completion is issued for it. Requests presented during reset are not granted.
- Request-to-response latency is exactly 1 cycle. Back-to-back grants produce back-to-back responses.
- Write to address A at cycle t, then read of A at cycle t+1 (either client): the read returns the new data at t+2.
- Both clients continuously valid: grants strictly alternate 0,1,0,1,… A waiting client is granted within 1 cycle of the contention.
- A lone client valid every cycle is granted every cycle, regardless of `last`.
- All address and data arithmetic is pass-through. No width conversion takes place.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with both clients valid. Required: no ready, no `resp_valid`, `mem_we`=0 throughout. Release reset with both valid. Required: client 0 granted first.
- **Write/read, one client:** client 0 writes 0xDEADBEEF_0000_0001 to addr 3, then reads addr 3. Required: `r0_resp_valid` on the cycle after each grant, and `r0_rdata`=0xDEADBEEF_0000_0001 on the read response.
- **Contention:** both clients read continuously for 8 cycles (client 0 at addr 1, client 1 at addr 2, preloaded with 0x11 and 0x22). Required: grants alternate 0,1,0,1,…, and each response carries its client's value.
- **Cross-client forwarding:** client 1 writes 0x55 to addr 31 at cycle t, and client 0 reads addr 31 at t+1. Required: `r0_rdata`=0x55 at t+2, and `r1_resp_valid`=1 at t+1 with `r1_rdata`=0.
- **Reset mid-transaction:** assert `reset`=0 on the cycle after a read grant. Required: no `resp_valid` emitted. After release, the next contention is won by client 0.
- **Lone client and idle:** client 1 valid alone for 4 cycles. Required: 4 consecutive grants to client 1. Then idle. Required: `mem_we`=0, `mem_addr`=0 and no responses.

Source files
------------

// File: rtl/mem_arbiter_1rw.sv
// mem_arbiter_1rw
// Lets two clients share one single-port memory with synchronous read.
// The grant is combinational and round-robin. Each client gets its
// completion, and read data if any, exactly one cycle after its grant.
//
// Ports:
//   clock, reset        rising-edge clock; synchronous active-low reset
//   rN_valid/rN_ready   request handshake for client N (ready = grant)
//   rN_we/addr/wdata    client N request fields
//   rN_resp_valid       one-cycle completion pulse for client N
//   rN_rdata            client N read data (0 unless a read completes)
//   mem_addr/we/wdata   shared memory RW port, zero when idle
//   mem_rdata           memory read data, one cycle after the address
module mem_arbiter_1rw #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_resp_valid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic gnt0, gnt1;
  logic last_q, last_d;
  logic rsp_v_q, rsp_v_d;
  logic rsp_id_q, rsp_id_d;
  logic rsp_we_q, rsp_we_d;

  // Nothing is granted while reset is held. On contention the client
  // that did not win last time gets the grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (r0_valid && r1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_addr  = r0_addr;
      mem_we    = r0_we;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_addr  = r1_addr;
      mem_we    = r1_we;
      mem_wdata = r1_wdata;
    end
  end

  always_comb begin
    last_d   = last_q;
    rsp_v_d  = gnt0 || gnt1;
    rsp_id_d = gnt1;
    rsp_we_d = mem_we;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
    end
  end

  // Reset leaves last = 1 so client 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q   <= 1'b1;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_we_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
      rsp_we_q <= rsp_we_d;
    end
  end

  // Responses are gated by reset. A response still pending when reset
  // asserts is therefore dropped in that same cycle.
  logic rsp_live;
  logic rsp_rd;

  assign rsp_live = reset && rsp_v_q;
  assign rsp_rd   = rsp_live && !rsp_we_q;

  assign r0_resp_valid = rsp_live && !rsp_id_q;
  assign r1_resp_valid = rsp_live && rsp_id_q;
  assign r0_rdata      = (rsp_rd && !rsp_id_q) ? mem_rdata : '0;
  assign r1_rdata      = (rsp_rd && rsp_id_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_1rw.sv
module tb_mem_arbiter_1rw;

  logic        clock;
  logic        reset;
  logic        r0_valid, r0_ready, r0_we, r0_resp_valid;
  logic [4:0]  r0_addr;
  logic [63:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_resp_valid;
  logic [4:0]  r1_addr;
  logic [63:0] r1_wdata, r1_rdata;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  mem_arbiter_1rw #(.ADDR_W(5), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_resp_valid(r0_resp_valid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_resp_valid(r1_resp_valid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural 32x64 single-port memory with synchronous read.
  logic [63:0] mem [32];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic we0, input logic [4:0] a0,
                         input logic [63:0] d0, input logic v1, input logic we1,
                         input logic [4:0] a1, input logic [63:0] d1);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;

    // Reset held with both clients requesting.
    for (int i = 0; i < 3; i++) begin
      set_req(1, 0, 5'd0, 64'd0, 1, 0, 5'd0, 64'd0);
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_r0_resp", r0_resp_valid, 0);
      chk("rst_r1_resp", r1_resp_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      tick();
    end

    reset = 1'b1;
    set_req(1, 0, 5'd0, 64'd0, 1, 0, 5'd0, 64'd0);
    chk("first_r0_ready", r0_ready, 1);
    chk("first_r1_ready", r1_ready, 0);
    tick();
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("first_r0_resp", r0_resp_valid, 1);
    chk("first_r1_resp", r1_resp_valid, 0);
    tick();

    // Client 0 write then read of addr 3.
    set_req(1, 1, 5'd3, 64'hDEADBEEF_0000_0001, 0, 0, 5'd0, 64'd0);
    chk("wr_r0_ready", r0_ready, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 3);
    chk("wr_mem_wdata", mem_wdata, 64'hDEADBEEF_0000_0001);
    tick();
    set_req(1, 0, 5'd3, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("wr_resp", r0_resp_valid, 1);
    chk("wr_rdata_zero", r0_rdata, 0);
    chk("rd_mem_we", mem_we, 0);
    tick();
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("rd_resp", r0_resp_valid, 1);
    chk("rd_rdata", r0_rdata, 64'hDEADBEEF_0000_0001);
    tick();

    // Preload addr 1 and 2; last ends as client 0.
    set_req(1, 1, 5'd1, 64'h11, 0, 0, 5'd0, 64'd0);
    tick();
    set_req(1, 1, 5'd2, 64'h22, 0, 0, 5'd0, 64'd0);
    tick();

    // Contention: last = 0, so client 1 goes first, then alternate.
    for (int i = 0; i < 8; i++) begin
      set_req(1, 0, 5'd1, 64'd0, 1, 0, 5'd2, 64'd0);
      chk("cont_r0_ready", r0_ready, (i % 2) == 1);
      chk("cont_r1_ready", r1_ready, (i % 2) == 0);
      if (i > 0) begin
        if ((i % 2) == 1) begin
          chk("cont_r1_resp", r1_resp_valid, 1);
          chk("cont_r1_rdata", r1_rdata, 64'h22);
          chk("cont_r0_resp_idle", r0_resp_valid, 0);
        end else begin
          chk("cont_r0_resp", r0_resp_valid, 1);
          chk("cont_r0_rdata", r0_rdata, 64'h11);
          chk("cont_r1_resp_idle", r1_resp_valid, 0);
        end
      end
      tick();
    end
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("cont_last_r0_resp", r0_resp_valid, 1);
    chk("cont_last_r0_rdata", r0_rdata, 64'h11);
    tick();

    // Cross-client write then read of addr 31.
    set_req(0, 0, 5'd0, 64'd0, 1, 1, 5'd31, 64'h55);
    chk("x_r1_ready", r1_ready, 1);
    tick();
    set_req(1, 0, 5'd31, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("x_r1_resp", r1_resp_valid, 1);
    chk("x_r1_rdata", r1_rdata, 0);
    chk("x_r0_ready", r0_ready, 1);
    tick();
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("x_r0_resp", r0_resp_valid, 1);
    chk("x_r0_rdata", r0_rdata, 64'h55);
    chk("x_r1_resp_idle", r1_resp_valid, 0);
    tick();

    // Reset right after a client-0 read grant.
    set_req(1, 0, 5'd1, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("mr_r0_ready", r0_ready, 1);
    tick();
    reset = 1'b0;
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("mr_r0_resp", r0_resp_valid, 0);
    chk("mr_r0_rdata", r0_rdata, 0);
    tick();
    reset = 1'b1;
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("mr_after_r0_resp", r0_resp_valid, 0);
    chk("mr_after_r1_resp", r1_resp_valid, 0);
    tick();
    set_req(1, 0, 5'd1, 64'd0, 1, 0, 5'd2, 64'd0);
    chk("mr_cont_r0_ready", r0_ready, 1);
    chk("mr_cont_r1_ready", r1_ready, 0);
    tick();
    set_req(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0);
    chk("mr_cont_r0_rdata", r0_rdata, 64'h11);
    tick();

    // Lone client 1 for four cycles.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 5'd0, 64'd0, 1, 0, 5'd2, 64'd0);
      chk("lone_r1_ready", r1_ready, 1);
      chk("lone_r0_ready", r0_ready, 0);
      if (i > 0) chk("lone_r1_rdata", r1_rdata, 64'h22);
      tick();
    end

    // Idle with non-zero request fields but no valid.
    set_req(0, 1, 5'd7, 64'hAA, 0, 1, 5'd9, 64'hBB);
    chk("idle_last_r1_resp", r1_resp_valid, 1);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);
    tick();
    set_req(0, 1, 5'd7, 64'hAA, 0, 1, 5'd9, 64'hBB);
    chk("idle_r0_resp", r0_resp_valid, 0);
    chk("idle_r1_resp", r1_resp_valid, 0);
    chk("idle_r1_rdata", r1_rdata, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
